// File: rtl/awg_pkg.sv
// Shared types and default widths for the AWG sweep controller.
package awg_pkg;

  localparam int FREQ_W  = 12;
  localparam int AMP_W   = 3;
  localparam int PHASE_W = 8;
  localparam int DWELL_W = 16;
  localparam int REP_W   = 8;

  localparam int AMP_MIN = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/awg_dwell_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module awg_dwell_timer
  import awg_pkg::*;
#(
  parameter int W = DWELL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Frequency sweep / burst scheduler driving one waveform generator.
module awg_sweep_ctrl #(
  parameter int FREQ_W  = awg_pkg::FREQ_W,
  parameter int AMP_W   = awg_pkg::AMP_W,
  parameter int PHASE_W = awg_pkg::PHASE_W,
  parameter int DWELL_W = awg_pkg::DWELL_W,
  parameter int REP_W   = awg_pkg::REP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FREQ_W-1:0]  cfg_f_start,
  input  logic [FREQ_W-1:0]  cfg_f_stop,
  input  logic [FREQ_W-1:0]  cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic [REP_W-1:0]   cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic               gen_en,
  output logic [FREQ_W-1:0]  gen_freq,
  output logic [AMP_W-1:0]   gen_amp,
  output logic [PHASE_W-1:0] gen_phase,
  output logic               busy,
  output logic               done,
  output logic               pass_wrap
);

  import awg_pkg::*;

  localparam logic [AMP_W-1:0] AMP_ONE = AMP_W'(AMP_MIN);

  state_t state_q, state_d;

  logic [FREQ_W-1:0]  start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [AMP_W-1:0]   amp_q;
  logic [PHASE_W-1:0] phase_q;
  logic [REP_W-1:0]   rep_q;
  logic               up_q;

  logic [REP_W-1:0]   rem_q, rem_d;
  logic               en_q, en_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [AMP_W-1:0]   gamp_q, gamp_d;
  logic [PHASE_W-1:0] gph_q, gph_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;

  logic               xfer, go, again, pass_end;
  logic               expire, load;
  logic [AMP_W-1:0]   amp_ok;
  logic [FREQ_W-1:0]  eff_start, nxt;
  logic [DWELL_W-1:0] eff_dwell, tmr_val;
  logic [AMP_W-1:0]   eff_amp;
  logic [PHASE_W-1:0] eff_phase;
  logic [REP_W-1:0]   eff_rep;
  logic [FREQ_W:0]    sum, diff;

  assign cfg_ready = (state_q == IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign go        = cfg_ready && start && !abort;
  assign amp_ok    = (cfg_amp == '0) ? AMP_ONE : cfg_amp;

  // A same-cycle transfer must feed the start that accompanies it.
  assign eff_start = xfer ? cfg_f_start : start_q;
  assign eff_dwell = xfer ? cfg_dwell   : dwell_q;
  assign eff_amp   = xfer ? amp_ok      : amp_q;
  assign eff_phase = xfer ? cfg_phase   : phase_q;
  assign eff_rep   = xfer ? cfg_repeat  : rep_q;
  assign tmr_val   = cfg_ready ? eff_dwell : dwell_q;

  assign sum      = {1'b0, freq_q} + {1'b0, step_q};
  assign diff     = {1'b0, freq_q} - {1'b0, step_q};
  assign pass_end = (freq_q == stop_q) || (step_q == '0);
  assign again    = (rem_q > REP_W'(1)) || (rep_q == '0);

  always_comb begin
    nxt = freq_q;
    unique case (1'b1)
      up_q: begin
        nxt = (sum > {1'b0, stop_q}) ? stop_q
                                     : sum[FREQ_W-1:0];
      end
      !up_q: begin
        nxt = (diff[FREQ_W] || diff[FREQ_W-1:0] < stop_q)
              ? stop_q : diff[FREQ_W-1:0];
      end
      default: nxt = freq_q;
    endcase
  end

  awg_dwell_timer #(
    .W(DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (tmr_val),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      amp_q   <= AMP_ONE;
      phase_q <= '0;
      rep_q   <= REP_W'(1);
      up_q    <= 1'b1;
    end else if (xfer) begin
      start_q <= cfg_f_start;
      stop_q  <= cfg_f_stop;
      step_q  <= cfg_f_step;
      dwell_q <= cfg_dwell;
      amp_q   <= amp_ok;
      phase_q <= cfg_phase;
      rep_q   <= cfg_repeat;
      up_q    <= (cfg_f_stop >= cfg_f_start);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      en_q    <= 1'b0;
      freq_q  <= '0;
      gamp_q  <= AMP_ONE;
      gph_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      freq_q  <= freq_d;
      gamp_q  <= gamp_d;
      gph_q   <= gph_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (expire && pass_end && !again) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rem_d  = rem_q;
    en_d   = en_q;
    freq_d = freq_q;
    gamp_d = gamp_q;
    gph_d  = gph_q;
    busy_d = busy_q;
    done_d = 1'b0;
    wrap_d = 1'b0;
    load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          en_d   = 1'b1;
          busy_d = 1'b1;
          freq_d = eff_start;
          gamp_d = eff_amp;
          gph_d  = eff_phase;
          rem_d  = eff_rep;
          load   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          en_d   = 1'b0;
          busy_d = 1'b0;
        end else if (expire && pass_end && again) begin
          freq_d = start_q;
          wrap_d = 1'b1;
          load   = 1'b1;
          if (rep_q != '0) rem_d = rem_q - 1'b1;
        end else if (expire && pass_end) begin
          en_d   = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (expire) begin
          freq_d = nxt;
          load   = 1'b1;
        end
      end
      default: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign gen_en    = en_q;
  assign gen_freq  = freq_q;
  assign gen_amp   = gamp_q;
  assign gen_phase = gph_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_wrap = wrap_q;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Table-driven sweep traces scored through a queue, plus corner sequences.
module tb_awg_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [11:0] cfg_f_start, cfg_f_stop, cfg_f_step;
  logic [15:0] cfg_dwell;
  logic [2:0]  cfg_amp;
  logic [7:0]  cfg_phase, cfg_repeat;
  logic        start, abort;
  logic        gen_en, busy, done, pass_wrap;
  logic [11:0] gen_freq;
  logic [2:0]  gen_amp;
  logic [7:0]  gen_phase;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [11:0]      fs, fe, st;
    logic [15:0]      dw;
    logic [2:0]       amp;
    logic [7:0]       ph, rep;
    logic [3:0]       n;
    logic [3:0][11:0] pts;
    logic [2:0]       xamp;
  } vec_t;

  typedef struct packed {
    logic        en, busy, done, wrap;
    logic [11:0] freq;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];

  always #5 clk = ~clk;

  awg_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop),
    .cfg_f_step(cfg_f_step), .cfg_dwell(cfg_dwell),
    .cfg_amp(cfg_amp), .cfg_phase(cfg_phase),
    .cfg_repeat(cfg_repeat),
    .start(start), .abort(abort),
    .gen_en(gen_en), .gen_freq(gen_freq),
    .gen_amp(gen_amp), .gen_phase(gen_phase),
    .busy(busy), .done(done), .pass_wrap(pass_wrap)
  );

  function automatic vec_t mk(
    input int fs, fe, st, dw, amp, ph, rep, n,
    input int p0, p1, p2, p3, xamp);
    vec_t v;
    v.fs = 12'(fs); v.fe = 12'(fe); v.st = 12'(st);
    v.dw = 16'(dw); v.amp = 3'(amp); v.ph = 8'(ph);
    v.rep = 8'(rep); v.n = 4'(n);
    v.pts[0] = 12'(p0); v.pts[1] = 12'(p1);
    v.pts[2] = 12'(p2); v.pts[3] = 12'(p3);
    v.xamp = 3'(xamp);
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    cfg_f_start = v.fs; cfg_f_stop = v.fe;
    cfg_f_step = v.st; cfg_dwell = v.dw;
    cfg_amp = v.amp; cfg_phase = v.ph;
    cfg_repeat = v.rep;
  endtask

  task automatic launch(input vec_t v, input bit use_cfg);
    @(negedge clk);
    if (use_cfg) begin
      set_cfg(v);
      cfg_valid = 1'b1;
    end
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v,
                         input bit use_cfg);
    exp_t e;
    for (int p = 0; p < int'(v.rep); p++)
      for (int k = 0; k < int'(v.n); k++)
        for (int c = 0; c <= int'(v.dw); c++) begin
          e.en = 1'b1; e.busy = 1'b1; e.done = 1'b0;
          e.wrap = (p > 0 && k == 0 && c == 0);
          e.freq = v.pts[k];
          sb.push_back(e);
        end
    e.en = 1'b0; e.busy = 1'b0; e.done = 1'b1;
    e.wrap = 1'b0; e.freq = v.pts[v.n - 4'd1];
    sb.push_back(e);
    e.done = 1'b0;
    sb.push_back(e);
    launch(v, use_cfg);
    chk({nm, "_amp"}, 32'(gen_amp), 32'(v.xamp));
    chk({nm, "_phase"}, 32'(gen_phase), 32'(v.ph));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(nm, 32'({gen_en, busy, done, pass_wrap, gen_freq}),
          32'(e));
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t va, vb;
    int   wraps, dones;
    bit   hit;

    tbl[0] = mk(100, 130, 10, 2, 3, 'h5A, 1, 4,
                100, 110, 120, 130, 3);
    tbl[1] = mk(100, 125, 10, 0, 5, 'h01, 1, 4,
                100, 110, 120, 125, 5);
    tbl[2] = mk(50, 20, 15, 1, 2, 'h80, 1, 3,
                50, 35, 20, 0, 2);
    tbl[3] = mk(10, 0, 15, 0, 4, 'hFF, 1, 2,
                10, 0, 0, 0, 4);
    tbl[4] = mk(5, 7, 1, 0, 1, 'h00, 2, 3,
                5, 6, 7, 0, 1);
    tbl[5] = mk(40, 90, 0, 3, 0, 'h33, 1, 1,
                40, 0, 0, 0, 1);
    tbl[6] = mk(77, 77, 5, 1, 6, 'h10, 1, 1,
                77, 0, 0, 0, 6);
    tbl[7] = mk(4090, 4095, 4, 0, 7, 'h42, 1, 3,
                4090, 4094, 4095, 0, 7);

    rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0;
    abort = 1'b0;
    set_cfg(tbl[0]);
    repeat (2) @(negedge clk);
    chk("reset_out", 32'({gen_en, busy, done, pass_wrap,
        gen_freq, gen_amp, gen_phase}), 32'({4'b0, 12'd0,
        3'd1, 8'd0}));
    chk("reset_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), tbl[i], 1'b1);

    // abort during the 110 point
    launch(tbl[0], 1'b1);
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (gen_freq == 12'd110) hit = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach", 32'(hit), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_out", 32'({gen_en, busy, done, cfg_ready}),
        32'(4'b0001));
    @(negedge clk);
    chk("abort_nodone", 32'(done), 32'd0);

    // start with abort in IDLE stays idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort", 32'({gen_en, busy, cfg_ready}),
        32'(3'b001));

    // cfg offered while running is ignored
    va = mk(5, 7, 1, 0, 2, 'h11, 1, 3, 5, 6, 7, 0, 2);
    vb = mk(200, 300, 50, 5, 7, 'h99, 3, 3,
            200, 250, 300, 0, 7);
    launch(va, 1'b1);
    set_cfg(vb);
    cfg_valid = 1'b1;
    chk("run_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (!busy) hit = 1'b1;
      else @(negedge clk);
    end
    chk("run_idle", 32'(hit), 32'd1);
    run_vec("shadow", va, 1'b0);

    // infinite repeat until abort
    va = mk(5, 7, 1, 0, 1, 'h00, 0, 3, 5, 6, 7, 0, 1);
    launch(va, 1'b1);
    wraps = 0; dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (pass_wrap) wraps++;
      if (done) dones++;
      @(negedge clk);
    end
    chk("inf_wraps", 32'(wraps >= 4), 32'd1);
    chk("inf_nodone", 32'(dones), 32'd0);
    chk("inf_busy", 32'({gen_en, busy}), 32'(2'b11));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("inf_abort", 32'({gen_en, busy, done}), 32'd0);

    // async reset between edges
    launch(tbl[0], 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out", 32'({gen_en, busy, done, pass_wrap,
        gen_freq, gen_amp, gen_phase}), 32'({4'b0, 12'd0,
        3'd1, 8'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("areset_idle", 32'({cfg_ready, busy, done}),
        32'(3'b100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/awg_sweep_ctrl.md
Name: awg_sweep_ctrl

Overview:
Frequency-sweep and burst scheduler for one waveform generator channel (saw/sine/square generator with freq/amp/phase/en inputs).
- Accepts a sweep configuration over a valid/ready handshake.
- On start, steps the generator's frequency word from a start value to a stop value, holding each point for a programmable dwell.
- Repeats the pass N times or forever, then disables the generator.
- Sits between the host register bank and the generator instance.

Parameters:
FREQ_W, 12, frequency/phase-increment word width
AMP_W, 3, amplitude divisor width
PHASE_W, 8, phase offset width
DWELL_W, 16, dwell counter width
REP_W, 8, repeat count width (0 = infinite)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted this cycle if cfg_valid=1
cfg_f_start  in  FREQ_W  first frequency point
cfg_f_stop  in  FREQ_W  last frequency point
cfg_f_step  in  FREQ_W  step magnitude (direction derived)
cfg_dwell  in  DWELL_W  point hold = cfg_dwell+1 cycles
cfg_amp  in  AMP_W  amplitude code passed to generator
cfg_phase  in  PHASE_W  phase code passed to generator
cfg_repeat  in  REP_W  pass count, 0 = run until abort
start  in  1  begin sweep (level sampled, acts in IDLE only)
abort  in  1  stop immediately
gen_en  out  1  generator enable
gen_freq  out  FREQ_W  generator frequency word
gen_amp  out  AMP_W  generator amplitude code
gen_phase  out  PHASE_W  generator phase code
busy  out  1  high in RUN
done  out  1  one-cycle pulse at normal completion
pass_wrap  out  1  one-cycle pulse when a pass restarts at f_start

Behaviour:
- Reset (async, rst_n=0): state IDLE; gen_en=0, gen_freq=0, gen_amp=1, gen_phase=0, busy=0, done=0, pass_wrap=0. Shadow config cleared, with amp=1 and repeat=1.
- Reset mid-sweep: outputs take their reset values immediately, with no done pulse.
- States: IDLE, RUN. done is a registered pulse on the RUN->IDLE transition, not a state.
- cfg_ready=1 only in IDLE. A transfer occurs on cfg_valid&&cfg_ready and latches all cfg_* into shadow registers. cfg_valid outside IDLE is ignored.
- cfg_amp=0 is illegal for the generator (divide-by-zero). It is latched as 1.
- Direction: up if f_stop>=f_start, else down. Direction is fixed at latch time.
- IDLE->RUN: start=1 and abort=0 at edge N.
  - From edge N: gen_freq=f_start, gen_amp/gen_phase=shadow values, gen_en=1, busy=1.
  - A transfer and a start in the same cycle use the newly latched config.
- Dwell: gen_freq holds for exactly dwell+1 cycles per point. The counter loads dwell on every point change and decrements to 0.
- At dwell expiry, with cur = current point:
  - Up: next = cur+step, computed in FREQ_W+1 bits. If next>f_stop, next=f_stop.
  - Down: next = cur-step, computed in FREQ_W+1 bits. If a borrow occurs or next<f_stop, next=f_stop.
  - If cur==f_stop, or step==0, the pass ends instead of stepping. The stop point is always visited exactly once per pass.
- Pass end:
  - If remaining>1, or repeat==0: gen_freq=f_start next cycle, pass_wrap=1 for one cycle, and remaining decrements (not when infinite).
  - Otherwise: RUN->IDLE with gen_en=0, busy=0, done=1 for one cycle. gen_freq holds its last value.
- f_start==f_stop: a one-point pass.
- abort=1 in RUN: next edge goes to IDLE, gen_en=0, busy=0, no done pulse. Abort and start in the same cycle: abort wins.
- gen_amp/gen_phase change only on IDLE->RUN.
- All outputs are registered. Latency start→gen_en is 1 cycle.

Decomposition:
- Package awg_pkg holds:
  - the state enum (IDLE, RUN);
  - the width constants FREQ_W/AMP_W/PHASE_W/DWELL_W/REP_W and their defaults;
  - the constant AMP_MIN=1.
- Sub-module awg_dwell_timer holds the loadable down-counter. It takes load/value inputs and produces an expire output that pulses when the count is 0.
- Next-point arithmetic stays inline.

Test Plan:
- Up sweep: start=100, stop=130, step=10, dwell=2, repeat=1 → gen_freq 100,110,120,130 each for 3 cycles; gen_en high 12 cycles; done pulse on cycle 13; busy low after.
- Clamp and down sweep:
  - start=100, stop=125, step=10, dwell=0 → freq 100,110,120,125 then done.
  - start=50, stop=20, step=15 → 50,35,20.
  - start=10, stop=0, step=15 → 10,0, with no wrap below 0.
- Repeat: start=5, stop=7, step=1, dwell=0, repeat=2 → 5,6,7,5,6,7; pass_wrap pulses once, on the second 5; done after the second 7. With repeat=0, sweep runs ≥4 passes until abort.
- Abort: abort asserted during the 110 dwell of scenario 1 → gen_en=0 next edge, no done pulse, cfg_ready=1. Start+abort asserted together in IDLE → remains IDLE.
- Handshake/illegal values:
  - cfg_valid during RUN → cfg_ready=0, shadow unchanged on the next run.
  - cfg_amp=0 → gen_amp=1.
  - step=0 → single point at f_start for dwell+1 cycles.
- Async reset: rst_n low mid-RUN between clock edges → all outputs at reset values immediately; after release, IDLE with cfg_ready=1.
